// File: rtl/mem_arbiter.sv
// Two-port arbiter sharing one memory between fetch and data stages.
// Data wins ties until a bounded streak forces a fetch grant.
module mem_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int FAIRNESS = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              mem_valid,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              stall_if,
  output logic              stall_mem
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GNT_IF = 2'd1,
    GNT_D  = 2'd2
  } state_t;

  localparam logic [1:0] FAIR = 2'(FAIRNESS);

  state_t            state;
  logic [1:0]        streak;
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic [DATA_W-1:0] wdata_q;

  logic fetch_wins;
  logic granted;
  logic if_done;
  logic d_done;

  // Fetch only loses a tie while the data streak is below the bound.
  assign fetch_wins = if_req && (!d_req || streak == FAIR);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      streak  <= 2'd0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (fetch_wins) begin
            state   <= GNT_IF;
            addr_q  <= if_addr;
            we_q    <= 1'b0;
            wdata_q <= '0;
            streak  <= 2'd0;
          end else if (d_req) begin
            state   <= GNT_D;
            addr_q  <= d_addr;
            we_q    <= d_we;
            wdata_q <= d_wdata;
            if (!if_req)
              streak <= 2'd0;
            else if (streak != FAIR)
              streak <= streak + 2'd1;
          end
        end
        GNT_IF, GNT_D: begin
          if (mem_ack)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs are forced quiet while reset is held, even mid-grant.
  always_comb begin
    granted = rst_n && (state != IDLE);
    if_done = rst_n && (state == GNT_IF) && mem_ack;
    d_done  = rst_n && (state == GNT_D) && mem_ack;
  end

  assign mem_valid = granted;
  assign mem_we    = granted && we_q;
  assign mem_addr  = granted ? addr_q : '0;
  assign mem_wdata = granted ? wdata_q : '0;

  assign if_ready = if_done;
  assign d_ready  = d_done;
  assign if_rdata = if_done ? mem_rdata : '0;
  assign d_rdata  = d_done ? mem_rdata : '0;

  assign stall_if  = if_req && !if_done;
  assign stall_mem = d_req && !d_done;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: memory model with programmable
// ack latency and a scoreboard of expected completions.
module tb_mem_arbiter;

  typedef struct {
    logic        is_if;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ready;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_ready;
  logic        mem_valid;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        stall_if;
  logic        stall_mem;

  int checks = 0;
  int errors = 0;
  int mem_lat = 0;
  logic force_ack = 1'b0;

  txn_t sb[$];
  txn_t d_list[$];
  txn_t i_list[$];

  mem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr),
    .if_rdata(if_rdata), .if_ready(if_ready),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_rdata(d_rdata), .d_ready(d_ready),
    .mem_valid(mem_valid), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .stall_if(stall_if), .stall_mem(stall_mem)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rd_model(input logic [31:0] a);
    return (a == 32'h100) ? 32'h13 : {a[15:0], ~a[15:0]};
  endfunction

  function automatic txn_t mk(input logic i, input logic w,
                              input logic [31:0] a, input logic [31:0] d);
    txn_t t;
    t.is_if = i; t.we = w; t.addr = a; t.wdata = d;
    return t;
  endfunction

  // Memory: acks after mem_lat wait cycles of a continuous request.
  initial begin
    int wcnt;
    wcnt = 0;
    mem_ack = 1'b0;
    mem_rdata = 32'hBAD0_BAD0;
    forever begin
      @(posedge clk); #2;
      if (mem_valid && rst_n) begin
        mem_ack = (wcnt >= mem_lat);
        mem_rdata = mem_ack ? rd_model(mem_addr) : 32'hBAD0_BAD0;
        wcnt++;
      end else begin
        wcnt = 0;
        mem_ack = force_ack;
        mem_rdata = 32'hBAD0_BAD0;
      end
    end
  end

  // Per-cycle monitor and scoreboard consumer.
  initial begin
    logic        pv, pr;
    logic        pwe;
    logic [31:0] pa, pd;
    int vcnt;
    txn_t e;
    pv = 0; pr = 0; pwe = 0; pa = 0; pd = 0; vcnt = 0;
    forever begin
      @(negedge clk);
      chk("stall_if", stall_if, if_req && !if_ready);
      chk("stall_mem", stall_mem, d_req && !d_ready);
      if (!if_ready) chk("if_rdata_zero", if_rdata, 0);
      if (!d_ready) chk("d_rdata_zero", d_rdata, 0);
      if (!mem_valid) begin
        chk("idle_addr", mem_addr, 0);
        chk("idle_we", mem_we, 0);
        chk("idle_wdata", mem_wdata, 0);
        chk("idle_no_ready", {if_ready, d_ready}, 0);
      end
      if (pv && mem_valid) begin
        chk("stable_addr", mem_addr, pa);
        chk("stable_we", mem_we, pwe);
        chk("stable_wdata", mem_wdata, pd);
      end
      vcnt = mem_valid ? vcnt + 1 : 0;
      if (if_ready || d_ready) begin
        chk("sb_nonempty", sb.size() != 0, 1);
        chk("ready_single_pulse", pr, 0);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("grant_is_fetch", if_ready, e.is_if);
          chk("grant_is_data", d_ready, !e.is_if);
          chk("txn_addr", mem_addr, e.addr);
          chk("txn_we", mem_we, e.we);
          chk("txn_wdata", mem_wdata, e.wdata);
          chk("txn_rdata", e.is_if ? if_rdata : d_rdata, rd_model(e.addr));
          chk("txn_valid_cycles", vcnt, mem_lat + 1);
        end
      end
      pv = mem_valid; pr = if_ready || d_ready;
      pa = mem_addr; pwe = mem_we; pd = mem_wdata;
    end
  end

  task automatic drive_next();
    if_req = (i_list.size() > 0);
    if (i_list.size() > 0) if_addr = i_list[0].addr;
    d_req = (d_list.size() > 0);
    if (d_list.size() > 0) begin
      d_we = d_list[0].we;
      d_addr = d_list[0].addr;
      d_wdata = d_list[0].wdata;
    end
  endtask

  // Both requesters hold req until their ready, then move to the next item.
  task automatic traffic(input int lat, output int cycles);
    logic gi, gd;
    mem_lat = lat;
    cycles = 0;
    @(posedge clk); #1;
    drive_next();
    while ((d_list.size() > 0 || i_list.size() > 0) && cycles < 200) begin
      @(negedge clk);
      cycles++;
      gi = if_ready; gd = d_ready;
      @(posedge clk); #1;
      if (gi && i_list.size() > 0) i_list.delete(0);
      if (gd && d_list.size() > 0) d_list.delete(0);
      drive_next();
    end
    chk("traffic_done", d_list.size() + i_list.size(), 0);
  endtask

  initial begin
    int n;
    logic seen;
    rst_n = 0;
    if_req = 1; if_addr = 32'h100;
    d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;

    // Reset with fetch already requesting.
    repeat (2) @(negedge clk);
    chk("rst_mem_valid", mem_valid, 0);
    chk("rst_if_ready", if_ready, 0);
    chk("rst_stall_if", stall_if, 1);

    // Single fetch, immediate ack.
    mem_lat = 0;
    sb.push_back(mk(1, 0, 32'h100, 0));
    @(posedge clk); #1 rst_n = 1;
    @(negedge clk);
    chk("f_c0_valid", mem_valid, 0);
    @(negedge clk);
    chk("f_c1_valid", mem_valid, 1);
    chk("f_c1_addr", mem_addr, 32'h100);
    chk("f_c1_ready", if_ready, 1);
    chk("f_c1_rdata", if_rdata, 32'h13);
    @(posedge clk); #1 if_req = 0;
    @(negedge clk);
    chk("f_c2_idle", mem_valid, 0);

    // Ack while idle is ignored.
    @(posedge clk); #1 force_ack = 1;
    repeat (2) begin
      @(negedge clk);
      chk("idle_ack_ready", {if_ready, d_ready}, 0);
      chk("idle_ack_valid", mem_valid, 0);
    end
    @(posedge clk); #1 force_ack = 0;

    // Write with three wait cycles; requester changes after grant.
    mem_lat = 3;
    sb.push_back(mk(0, 1, 32'h2000, 32'hDEAD_BEEF));
    d_req = 1; d_we = 1; d_addr = 32'h2000; d_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("wr_stall_before", stall_mem, 1);
    @(posedge clk); #1;
    d_addr = 32'hFFFF_FFF0; d_wdata = 0; d_we = 0;
    n = 0; seen = 0;
    while (!seen && n < 20) begin
      @(negedge clk);
      n++;
      seen = d_ready;
      if (!seen) chk("wr_we_held", mem_we, 1);
    end
    chk("wr_latency", n, 4);
    @(posedge clk); #1 d_req = 0;

    // Simultaneous: data first, fetch after the bubble.
    d_list.push_back(mk(0, 0, 32'h3000, 0));
    i_list.push_back(mk(1, 0, 32'h104, 0));
    sb.push_back(d_list[0]);
    sb.push_back(i_list[0]);
    traffic(0, n);
    chk("sim_cycles", n, 4);

    // Fairness: three data grants, one fetch, then data.
    for (int k = 0; k < 4; k++)
      d_list.push_back(mk(0, k[0], 32'h5000 + 32'(k * 4), 32'h1000 + 32'(k)));
    i_list.push_back(mk(1, 0, 32'h200, 0));
    for (int k = 0; k < 3; k++) sb.push_back(d_list[k]);
    sb.push_back(i_list[0]);
    sb.push_back(d_list[3]);
    traffic(1, n);
    chk("fair_cycles", n, 15);

    // Streak restarts from zero after a data grant with no fetch waiting.
    for (int k = 0; k < 3; k++)
      d_list.push_back(mk(0, 1, 32'h6000 + 32'(k * 4), 32'hA0 + 32'(k)));
    i_list.push_back(mk(1, 0, 32'h300, 0));
    i_list.push_back(mk(1, 0, 32'h304, 0));
    for (int k = 0; k < 3; k++) sb.push_back(d_list[k]);
    sb.push_back(i_list[0]);
    sb.push_back(i_list[1]);
    traffic(0, n);
    chk("fair2_cycles", n, 10);

    // Fetch requester drops req mid-grant; transaction still completes.
    mem_lat = 2;
    sb.push_back(mk(1, 0, 32'h180, 0));
    @(posedge clk); #1 if_req = 1; if_addr = 32'h180;
    @(negedge clk);
    @(negedge clk);
    chk("drop_granted", mem_valid, 1);
    @(posedge clk); #1 if_req = 0;
    n = 0; seen = 0;
    while (!seen && n < 10) begin
      @(negedge clk);
      n++;
      seen = if_ready;
    end
    chk("drop_ready_seen", seen, 1);

    // Reset during a pending data grant, then a late ack.
    mem_lat = 100;
    @(posedge clk); #1 d_req = 1; d_we = 0; d_addr = 32'h4000;
    n = 0; seen = 0;
    while (!seen && n < 10) begin
      @(negedge clk);
      n++;
      seen = mem_valid;
    end
    chk("rg_granted", seen, 1);
    @(negedge clk);
    @(posedge clk); #1 rst_n = 0;
    @(negedge clk);
    chk("rg_valid_drop", mem_valid, 0);
    chk("rg_no_ready", d_ready, 0);
    chk("rg_stall_mem", stall_mem, 1);
    @(negedge clk);
    chk("rg_valid_next", mem_valid, 0);
    @(posedge clk); #1 d_req = 0; force_ack = 1;
    @(negedge clk);
    chk("rg_late_ack_rst", d_ready, 0);
    @(posedge clk); #1 rst_n = 1;
    repeat (2) begin
      @(negedge clk);
      chk("rg_late_ack", {if_ready, d_ready}, 0);
      chk("rg_late_valid", mem_valid, 0);
    end
    @(posedge clk); #1 force_ack = 0;

    // Normal operation resumes after reset.
    i_list.push_back(mk(1, 0, 32'h400, 0));
    sb.push_back(i_list[0]);
    traffic(0, n);
    chk("post_rst_cycles", n, 2);

    repeat (2) @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
